if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS CPU: holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. It is driven directly by the hazard unit's `pc_write` and `IFID_write` stall controls and by branch/jump redirects from later stages. It feeds the decode stage and returns the IF/ID `rs`/`rt` fields to the hazard unit's comparators. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; word aligned.
- `ADDR_W`, default 32: PC/address width; minimum 3.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pc_write`  in  1  from the hazard unit; 1 = PC may advance, 0 = hold the PC.
- `IFID_write`  in  1  from the hazard unit; 1 = IF/ID may load, 0 = hold IF/ID.
- `branch_taken`  in  1  taken branch resolved in EX.
- `branch_target`  in  ADDR_W  branch destination.
- `jump`  in  1  jump decoded in ID.
- `jump_target`  in  ADDR_W  jump destination.
- `imem_addr`  out  ADDR_W  current PC; combinational from the PC register.
- `imem_data`  in  32  instruction word at `imem_addr`; combinational, same cycle.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc4`  out  ADDR_W  registered PC+4 of that instruction.
- `ifid_valid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- `ifid_rs`  out  5  `ifid_instr[25:21]`, to the hazard unit `rs1`.
- `ifid_rt`  out  5  `ifid_instr[20:16]`, to the hazard unit `rt2`.
- `stall_count`  out  16  saturating count of PC-stall cycles.

## Operation

- Redirect priority is branch_taken, then jump, then pc_write. The branch wins because it is the older instruction.
- Targets have bits [1:0] forced to 00 before being loaded into the PC.
- PC next-state at each edge:
  - `branch_taken` → aligned `branch_target`.
  - else `jump` → aligned `jump_target`.
  - else `pc_write` → PC+4.
  - else hold.
- A redirect overrides `pc_write`=0.
- PC+4 wraps modulo 2^ADDR_W. For ADDR_W=32, PC 32'hFFFF_FFFC advances to 32'h0.
- IF/ID next-state at each edge:
  - `branch_taken` or `jump` → flush: instr=32'h0 (NOP), pc4=0, valid=0.
  - else `IFID_write` → instr=`imem_data`, pc4=PC+4, valid=1.
  - else hold all three fields.
- A flush overrides `IFID_write`=0.
- `ifid_rs` and `ifid_rt` are pure slices of the registered `ifid_instr`, so both read 0 during a bubble.
- `pc_write` and `IFID_write` are independent. PC hold with IF/ID load, and the reverse, are both legal and must be honoured exactly.
- `stall_count` increments on each edge where `pc_write`=0 and no redirect is present. It saturates at 16'hFFFF. It is cleared only by reset.

## Timing

- Reset (asynchronous, takes effect immediately, independent of `clk`):
  - PC=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0.
  - `ifid_rs`=0, `ifid_rt`=0.
  - `stall_count`=0.
- Reset asserted mid-operation discards any in-flight redirect or stall.
- First fetch: the first rising edge after `rst` deasserts loads the instruction at `RESET_PC` into IF/ID.
- Fetch latency: 1 cycle from `imem_addr` to `ifid_instr`.
- Redirect sampled at edge N:
  - `imem_addr` shows the target after edge N.
  - IF/ID shows a bubble for cycle N+1.
  - The target instruction appears in IF/ID after edge N+1.
- Load-use stall (`pc_write`=`IFID_write`=0 for one cycle):
  - PC and IF/ID hold for exactly that cycle.
  - The same instruction is re-presented to the hazard unit.
- Simultaneous `branch_taken` and `jump`: the PC takes `branch_target`, and IF/ID is flushed once.

## Test plan

- Reset, then `rst` deasserted with `pc_write`=`IFID_write`=1 for 4 edges, and `imem_data`=PC-derived words:
  - `imem_addr` steps 0, 4, 8, C, 10.
  - `ifid_pc4` steps 4, 8, C, 10.
  - `ifid_valid`=1 from the first edge.
- Load-use stall with `pc_write`=`IFID_write`=0 for one edge at PC=8 and IF/ID instr=32'h8C22_0000:
  - PC stays 8; IF/ID is unchanged.
  - `ifid_rs`=1, `ifid_rt`=2.
  - `stall_count`=1.
  - Normal advance resumes on the next edge.
- `branch_taken`=1, `branch_target`=32'h40 while `pc_write`=0:
  - PC becomes 40 and `stall_count` is unchanged.
  - IF/ID becomes instr=0, valid=0.
  - The instruction at 0x40 appears in IF/ID one edge later.
- `branch_taken`=1 (target 0x80) and `jump`=1 (target 0x100) in the same cycle, with `jump_target` given as 32'h103:
  - PC becomes 0x80; exactly one bubble is inserted.
  - Separately, a jump alone to 32'h103 loads PC=0x100.
- Wrap and saturation:
  - PC preloaded via a branch to 32'hFFFF_FFFC, then one advance → PC=0.
  - 70000 consecutive `pc_write`=0 edges → `stall_count`=16'hFFFF and holds.
- Asynchronous `rst` pulse between clock edges mid-stream: all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: hazard-unit
// stall controls, redirects, instruction memory and the IF/ID register outputs.
interface if_stage_if #(
    parameter int ADDR_W = 32
);
    logic              pc_write;
    logic              IFID_write;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       ifid_instr;
    logic [ADDR_W-1:0] ifid_pc4;
    logic              ifid_valid;
    logic [4:0]        ifid_rs;
    logic [4:0]        ifid_rt;
    logic [15:0]       stall_count;

    // The fetch stage itself.
    modport master (
        input  pc_write, IFID_write, branch_taken, branch_target,
               jump, jump_target, imem_data,
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid,
               ifid_rs, ifid_rt, stall_count
    );

    // Hazard unit, later stages and instruction memory.
    modport slave (
        output pc_write, IFID_write, branch_taken, branch_target,
               jump, jump_target, imem_data,
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid,
               ifid_rs, ifid_rt, stall_count
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register with branch/jump redirect, IF/ID
// pipeline register with stall/flush, and a saturating PC-stall counter.
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    if_stage_if.master  bus
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc4_q;
    logic              valid_q;
    logic [15:0]       stall_q;
    logic              redirect;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign redirect = bus.branch_taken | bus.jump;

    // Branch outranks jump: it belongs to the older instruction in EX.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_next and no latch is inferred.
        pc_next = pc;
        if (bus.branch_taken)
            pc_next = {bus.branch_target[ADDR_W-1:2], 2'b00};
        else if (bus.jump)
            pc_next = {bus.jump_target[ADDR_W-1:2], 2'b00};
        else if (bus.pc_write)
            pc_next = pc_plus4;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (rst)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (redirect) begin
            instr_q <= 32'h0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.IFID_write) begin
            instr_q <= bus.imem_data;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    // Only genuine PC stalls count; a redirect during pc_write=0 is not a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= 16'h0;
        else if (!bus.pc_write && !redirect && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'h1;
    end

    assign bus.imem_addr   = pc;
    assign bus.ifid_instr  = instr_q;
    assign bus.ifid_pc4    = pc4_q;
    assign bus.ifid_valid  = valid_q;
    assign bus.ifid_rs     = instr_q[25:21];
    assign bus.ifid_rt     = instr_q[20:16];
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: fetch, stalls, redirects, wrap, counter
// saturation and asynchronous reset, each scenario checked inline.
module tb_if_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    if_stage_if #(.ADDR_W(32)) bus ();

    if_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Instruction memory: one lw at 0x4, PC-tagged words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C22_0000;
        return {16'h2400, a[15:0]};
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic set_ctrl(input logic pw, input logic iw, input logic bt, input logic [31:0] btgt,
                            input logic j, input logic [31:0] jtgt);
        bus.pc_write      = pw;
        bus.IFID_write    = iw;
        bus.branch_taken  = bt;
        bus.branch_target = btgt;
        bus.jump          = j;
        bus.jump_target   = jtgt;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e_rst;
        e_rst = 32'h0;
        rst = 1'b1;
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        n_checks++; if (bus.imem_addr !== e_rst) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, e_rst); end
        n_checks++; if (bus.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", bus.ifid_instr); end
        n_checks++; if (bus.ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", bus.ifid_pc4); end
        n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid); end
        n_checks++; if (bus.ifid_rs !== 5'd0 || bus.ifid_rt !== 5'd0) begin n_fail++; $display("FAIL reset_rs_rt: got %0d/%0d expected 0/0", bus.ifid_rs, bus.ifid_rt); end
        n_checks++; if (bus.stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0", bus.stall_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e_pc    = 32'(4 * k);
            e_instr = mem_word(32'(4 * (k - 1)));
            n_checks++; if (bus.imem_addr !== e_pc) begin n_fail++; $display("FAIL fetch_pc[%0d]: got %h expected %h", k, bus.imem_addr, e_pc); end
            n_checks++; if (bus.ifid_pc4 !== e_pc) begin n_fail++; $display("FAIL fetch_pc4[%0d]: got %h expected %h", k, bus.ifid_pc4, e_pc); end
            n_checks++; if (bus.ifid_instr !== e_instr) begin n_fail++; $display("FAIL fetch_instr[%0d]: got %h expected %h", k, bus.ifid_instr, e_instr); end
            n_checks++; if (bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d]: got %b expected 1", k, bus.ifid_valid); end
        end
    endtask

    task automatic test_load_use();
        reset_pulse();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h8 || bus.ifid_instr !== 32'h8C22_0000) begin n_fail++; $display("FAIL lu_setup: got pc %h instr %h expected 8 8c220000", bus.imem_addr, bus.ifid_instr); end
        set_ctrl(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL lu_pc_hold: got %h expected 8", bus.imem_addr); end
        n_checks++; if (bus.ifid_instr !== 32'h8C22_0000 || bus.ifid_pc4 !== 32'h8 || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL lu_ifid_hold: got %h/%h/%b expected 8c220000/8/1", bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid); end
        n_checks++; if (bus.ifid_rs !== 5'd1 || bus.ifid_rt !== 5'd2) begin n_fail++; $display("FAIL lu_rs_rt: got %0d/%0d expected 1/2", bus.ifid_rs, bus.ifid_rt); end
        n_checks++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_stall: got %0d expected 1", bus.stall_count); end
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'hC || bus.ifid_instr !== 32'h2400_0008 || bus.ifid_pc4 !== 32'hC) begin n_fail++; $display("FAIL lu_resume: got %h/%h/%h expected c/24000008/c", bus.imem_addr, bus.ifid_instr, bus.ifid_pc4); end
        n_checks++; if (bus.stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_resume_stall: got %0d expected 1", bus.stall_count); end
    endtask

    task automatic test_independent();
        set_ctrl(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL ind_pc_hold: got %h expected c", bus.imem_addr); end
        n_checks++; if (bus.ifid_instr !== 32'h2400_000C || bus.ifid_pc4 !== 32'h10) begin n_fail++; $display("FAIL ind_ifid_load: got %h/%h expected 2400000c/10", bus.ifid_instr, bus.ifid_pc4); end
        n_checks++; if (bus.stall_count !== 16'd2) begin n_fail++; $display("FAIL ind_stall: got %0d expected 2", bus.stall_count); end
        set_ctrl(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL ind_pc_adv: got %h expected 10", bus.imem_addr); end
        n_checks++; if (bus.ifid_instr !== 32'h2400_000C || bus.ifid_pc4 !== 32'h10 || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL ind_ifid_hold: got %h/%h/%b expected 2400000c/10/1", bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid); end
    endtask

    task automatic test_branch();
        set_ctrl(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_pc: got %h expected 40", bus.imem_addr); end
        n_checks++; if (bus.ifid_instr !== 32'h0 || bus.ifid_pc4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush: got %h/%h/%b expected 0/0/0", bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid); end
        n_checks++; if (bus.ifid_rs !== 5'd0 || bus.ifid_rt !== 5'd0) begin n_fail++; $display("FAIL br_rs_rt: got %0d/%0d expected 0/0", bus.ifid_rs, bus.ifid_rt); end
        n_checks++; if (bus.stall_count !== 16'd2) begin n_fail++; $display("FAIL br_stall: got %0d expected 2", bus.stall_count); end
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h44 || bus.ifid_instr !== 32'h2400_0040 || bus.ifid_pc4 !== 32'h44 || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL br_target: got %h/%h/%h/%b expected 44/24000040/44/1", bus.imem_addr, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid); end
    endtask

    task automatic test_branch_and_jump();
        set_ctrl(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h103);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h80) begin n_fail++; $display("FAIL bj_pc: got %h expected 80", bus.imem_addr); end
        n_checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL bj_flush: got %b/%h expected 0/0", bus.ifid_valid, bus.ifid_instr); end
        n_checks++; if (bus.stall_count !== 16'd2) begin n_fail++; $display("FAIL bj_stall: got %0d expected 2", bus.stall_count); end
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h84 || bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 32'h2400_0080) begin n_fail++; $display("FAIL bj_one_bubble: got %h/%b/%h expected 84/1/24000080", bus.imem_addr, bus.ifid_valid, bus.ifid_instr); end
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h103);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h100 || bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL jump_align: got %h/%b expected 100/0", bus.imem_addr, bus.ifid_valid); end
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h104 || bus.ifid_instr !== 32'h2400_0100 || bus.ifid_pc4 !== 32'h104) begin n_fail++; $display("FAIL jump_target: got %h/%h/%h expected 104/24000100/104", bus.imem_addr, bus.ifid_instr, bus.ifid_pc4); end
    endtask

    task automatic test_wrap();
        set_ctrl(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_preload: got %h expected fffffffc", bus.imem_addr); end
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", bus.imem_addr); end
        n_checks++; if (bus.ifid_pc4 !== 32'h0 || bus.ifid_instr !== 32'h2400_FFFC || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_ifid: got %h/%h/%b expected 0/2400fffc/1", bus.ifid_pc4, bus.ifid_instr, bus.ifid_valid); end
    endtask

    task automatic test_saturate();
        set_ctrl(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 1; i <= 70000; i++) begin
            @(negedge clk);
            if (i == 65532) begin
                n_checks++; if (bus.stall_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h expected fffe", bus.stall_count); end
            end
            if (i == 65533) begin
                n_checks++; if (bus.stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", bus.stall_count); end
            end
        end
        n_checks++; if (bus.stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", bus.stall_count); end
        n_checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_instr !== 32'h2400_FFFC) begin n_fail++; $display("FAIL sat_pc_hold: got %h/%h expected 0/2400fffc", bus.imem_addr, bus.ifid_instr); end
    endtask

    task automatic test_async_reset();
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        set_ctrl(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_instr !== 32'h0 || bus.ifid_pc4 !== 32'h0 || bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_ifid: got %h/%h/%h/%b expected 0/0/0/0", bus.imem_addr, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid); end
        n_checks++; if (bus.stall_count !== 16'h0 || bus.ifid_rs !== 5'd0 || bus.ifid_rt !== 5'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %h/%0d/%0d expected 0/0/0", bus.stall_count, bus.ifid_rs, bus.ifid_rt); end
        @(negedge clk);
        set_ctrl(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.imem_addr !== 32'h4 || bus.ifid_instr !== 32'h2400_0000 || bus.ifid_pc4 !== 32'h4 || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL async_first_fetch: got %h/%h/%h/%b expected 4/24000000/4/1", bus.imem_addr, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid); end
        n_checks++; if (bus.stall_count !== 16'h0) begin n_fail++; $display("FAIL async_stall: got %h expected 0", bus.stall_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fetch();
        test_load_use();
        test_independent();
        test_branch();
        test_branch_and_jump();
        test_wrap();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
